// File: rtl/gyro_spi_pkg.sv
// gyro_spi_pkg: shared state encoding and SPI mode-3 constants for the gyro SPI engine
package gyro_spi_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    localparam int BITS_PER_BYTE = 8;
    localparam int DEFAULT_CLK_DIV = 50;
    localparam logic CPOL = 1'b1;
    localparam logic CPHA = 1'b1;
    localparam logic SCLK_IDLE = 1'b1;
    localparam logic MOSI_IDLE = 1'b1;
endpackage

// File: rtl/spi_half_tick.sv
// spi_half_tick: counts CLK_DIV enabled cycles and pulses tick on each half-period wrap
module spi_half_tick #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = en && cnt == W'(CLK_DIV - 1);
    // divider counter, wraps to zero on the tick cycle
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/spi_byte_master.sv
// spi_byte_master: mode-3 MSB-first SPI byte shifter driven by a tx_begin strobe
module spi_byte_master
    import gyro_spi_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_begin,
    input  logic [7:0] tx_data,
    output logic       tx_end,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);
    state_t state_q, state_d;
    logic [7:0] tx_shift, rx_shift;
    logic [3:0] bit_cnt;
    logic tick, last;
    spi_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk(clk),
        .rst(rst),
        .en(state_q == SHIFT),
        .clr(state_q != SHIFT),
        .tick(tick)
    );
    assign last = tick && !sclk && bit_cnt == 4'(BITS_PER_BYTE - 1);
    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    // next state; DONE and any illegal encoding fall back to IDLE
    always_comb begin
        state_d = IDLE;
        state_d = state_q == IDLE  ? (tx_begin ? SHIFT : IDLE) :
                  state_q == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    end
    // shift datapath: drive mosi on falling sclk, sample miso on rising sclk
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk     <= SCLK_IDLE;
            mosi     <= MOSI_IDLE;
            tx_end   <= 1'b0;
            busy     <= 1'b0;
            rx_data  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    sclk   <= SCLK_IDLE;
                    mosi   <= MOSI_IDLE;
                    tx_end <= 1'b0;
                    busy   <= tx_begin;
                    if (tx_begin) begin
                        tx_shift <= tx_data;
                        bit_cnt  <= '0;
                    end
                end
                SHIFT: if (tick) begin
                    sclk <= ~sclk;
                    if (sclk) begin
                        mosi     <= tx_shift[7];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end else begin
                        rx_shift <= {rx_shift[6:0], miso};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (last) begin
                            rx_data <= {rx_shift[6:0], miso};
                            tx_end  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    tx_end <= 1'b0;
                    busy   <= 1'b0;
                    mosi   <= MOSI_IDLE;
                end
                default: begin
                    sclk   <= SCLK_IDLE;
                    mosi   <= MOSI_IDLE;
                    tx_end <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master: directed checks of three divider settings with loopback and slave models
module tb_spi_byte_master;
    logic clk = 1'b0, rst = 1'b1;
    logic tb2 = 1'b0, tb50 = 1'b0, tb1 = 1'b0;
    logic [7:0] d2 = '0, d50 = '0, d1 = '0;
    logic te2, te50, te1, bz2, bz50, bz1, sc2, sc50, sc1, mo2, mo50, mo1, mi50, mi1;
    logic [7:0] rx2, rx50, rx1;
    logic [7:0] sb50 = '0, sb1 = '0;
    logic [2:0] fc50 = '0, fc1 = '0;
    int checks = 0, errors = 0;
    int n, falls, rises, run, bad, bad_mo;
    logic [7:0] bits;
    logic p;

    always #5 clk = ~clk;

    spi_byte_master #(.CLK_DIV(2)) u2 (.clk(clk), .rst(rst), .tx_begin(tb2), .tx_data(d2), .tx_end(te2),
        .rx_data(rx2), .busy(bz2), .sclk(sc2), .mosi(mo2), .miso(mo2));
    spi_byte_master #(.CLK_DIV(50)) u50 (.clk(clk), .rst(rst), .tx_begin(tb50), .tx_data(d50), .tx_end(te50),
        .rx_data(rx50), .busy(bz50), .sclk(sc50), .mosi(mo50), .miso(mi50));
    spi_byte_master #(.CLK_DIV(1)) u1 (.clk(clk), .rst(rst), .tx_begin(tb1), .tx_data(d1), .tx_end(te1),
        .rx_data(rx1), .busy(bz1), .sclk(sc1), .mosi(mo1), .miso(mi1));

    // mode-3 slaves: shift the next bit out after every falling sclk, MSB first
    always @(negedge sc50) fc50 <= fc50 + 3'd1;
    always @(negedge sc1) fc1 <= fc1 + 3'd1;
    assign mi50 = sb50[3'd0 - fc50];
    assign mi1 = sb1[3'd0 - fc1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go2(input logic [7:0] d);
        @(negedge clk); tb2 = 1'b1; d2 = d;
        @(negedge clk); tb2 = 1'b0;
    endtask

    task automatic wait2(input int inj, input int stop, output int nn, output logic [7:0] bb,
                         output int ff, output int rr);
        logic pp;
        nn = 0; bb = '0; ff = 0; rr = 0; pp = sc2;
        while (!te2 && nn < 2000 && rr != stop) begin
            @(negedge clk); nn++;
            if (pp && !sc2) begin ff++; bb = {bb[6:0], mo2}; end
            if (!pp && sc2) rr++;
            pp = sc2;
            if (nn == inj) begin tb2 = 1'b1; d2 = 8'hFF; end
            if (nn == inj + 1) tb2 = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sclk", 32'(sc2), 1);
        chk("rst_mosi", 32'(mo2), 1);
        chk("rst_busy", 32'(bz2), 0);
        chk("rst_tx_end", 32'(te2), 0);
        chk("rst_rx", 32'(rx2), 0);
        // idle hold
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (sc2 !== 1'b1 || mo2 !== 1'b1 || te2 || bz2 || !sc50 || te50 || bz50 || !sc1 || te1 || bz1) bad++;
        end
        chk("idle_hold", bad, 0);
        // loopback E8
        go2(8'hE8);
        chk("t1_busy", 32'(bz2), 1);
        wait2(-1, 99, n, bits, falls, rises);
        chk("t1_lat", n, 32);
        chk("t1_mosi", 32'(bits), 32'hE8);
        chk("t1_falls", falls, 8);
        chk("t1_rises", rises, 8);
        chk("t1_rx", 32'(rx2), 32'hE8);
        chk("t1_busy_end", 32'(bz2), 1);
        @(negedge clk);
        chk("t1_tx_end_pulse", 32'(te2), 0);
        chk("t1_busy_low", 32'(bz2), 0);
        chk("t1_idle", 32'({sc2, mo2}), 3);
        // ignored tx_begin mid-shift and in DONE
        go2(8'h5A);
        wait2(10, 99, n, bits, falls, rises);
        chk("t4_lat", n, 32);
        chk("t4_mosi", 32'(bits), 32'h5A);
        chk("t4_rx", 32'(rx2), 32'h5A);
        tb2 = 1'b1;
        @(negedge clk); tb2 = 1'b0;
        chk("t4_tx_end_pulse", 32'(te2), 0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bz2 || !sc2 || te2) bad++;
        end
        chk("t4_no_restart", bad, 0);
        // slave returns A5, CLK_DIV 50
        sb50 = 8'hA5;
        @(negedge clk); tb50 = 1'b1; d50 = 8'h00;
        @(negedge clk); tb50 = 1'b0;
        n = 0; p = sc50; run = 1; bad = 0; bad_mo = 0; falls = 0;
        while (!te50 && n < 2000) begin
            @(negedge clk); n++;
            if (sc50 == p) run++;
            else begin
                if (run != 50) bad++;
                if (p) falls++;
                run = 1;
            end
            p = sc50;
            if (falls > 0 && mo50 !== 1'b0) bad_mo++;
        end
        chk("t2_lat", n, 800);
        chk("t2_rx", 32'(rx50), 32'hA5);
        chk("t2_falls", falls, 8);
        chk("t2_half_period", bad, 0);
        chk("t2_mosi_zero", bad_mo, 0);
        // back-to-back bytes, CLK_DIV 1
        for (int k = 0; k < 7; k++) begin
            sb1 = k == 0 ? 8'h00 : 8'(k * 17);
            @(negedge clk); tb1 = 1'b1; d1 = k == 0 ? 8'hE8 : 8'h00;
            @(negedge clk); tb1 = 1'b0;
            n = 0;
            while (!te1 && n < 2000) begin @(negedge clk); n++; end
            chk("t3_lat", n, 16);
            if (k > 0) chk("t3_rx", 32'(rx1), 32'(k * 17));
        end
        @(negedge clk);
        chk("t3_busy_low", 32'(bz1), 0);
        // reset after the 4th rising sclk
        go2(8'hC3);
        wait2(-1, 4, n, bits, falls, rises);
        chk("t5_rises", rises, 4);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("t5_sclk", 32'(sc2), 1);
        chk("t5_mosi", 32'(mo2), 1);
        chk("t5_busy", 32'(bz2), 0);
        chk("t5_rx", 32'(rx2), 0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (te2 || bz2) bad++;
        end
        chk("t5_no_tx_end", bad, 0);
        go2(8'h3C);
        wait2(-1, 99, n, bits, falls, rises);
        chk("t5_lat", n, 32);
        chk("t5_rx_after", 32'(rx2), 32'h3C);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
